// File: rtl/serial_out_ms.sv
// Serial pattern generator: shifts out a latched word of run-time length,
// LSB- or MSB-first, with a per-bit choice between two tick sources, an
// optional repeat count and a one-cycle DONE state that issues o_done_tick.
module serial_out_ms #(
  parameter int unsigned DATA_BIT     = 32,
  parameter int unsigned TICK_PER_BIT = 16,
  parameter int unsigned LEN_W        = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick_high,
  input  logic                i_tick_low,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [1:0]          i_idle_mode,
  input  logic                i_msb_first,
  input  logic [LEN_W-1:0]    i_bit_len,
  input  logic [7:0]          i_repeat_num,
  input  logic [DATA_BIT-1:0] i_data,
  input  logic [DATA_BIT-1:0] i_freq_mask,
  output logic                o_busy,
  output logic                o_bit_tick,
  output logic                o_data,
  output logic                o_done_tick
);

  localparam int unsigned IdxW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int unsigned CntW = LEN_W + 1;

  localparam logic [CntW-1:0] DataBitLen = CntW'(DATA_BIT);
  localparam logic [CntW-1:0] Zero       = '0;
  localparam logic [CntW-1:0] One        = CntW'(1);
  localparam logic [7:0]      TickLast   = 8'(TICK_PER_BIT - 1);

  localparam logic [1:0] ModeLow    = 2'b00;
  localparam logic [1:0] ModeHigh   = 2'b01;
  localparam logic [1:0] ModeKeep   = 2'b10;
  localparam logic [1:0] ModeRepeat = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Map a transmit-order index k to the pattern bit position for length len.
  function automatic logic [IdxW-1:0] pat_idx(input logic [CntW-1:0] len,
                                              input logic [CntW-1:0] k,
                                              input logic            msb);
    return msb ? IdxW'(len - k - One) : IdxW'(k);
  endfunction

  state_e              state_q, state_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic [DATA_BIT-1:0] mask_q, mask_d;
  logic [CntW-1:0]     len_q, len_d;
  logic                msb_q, msb_d;
  logic [7:0]          rep_q, rep_d;
  logic [7:0]          pass_q, pass_d;
  logic [7:0]          tick_q, tick_d;
  logic [CntW-1:0]     idx_q, idx_d;
  logic                out_q, out_d;
  logic                bit_tick_q, bit_tick_d;
  logic                done_tick_q, done_tick_d;
  logic                busy_q, busy_d;

  logic [CntW-1:0] bit_len_ext;
  logic [CntW-1:0] eff_len;
  logic [IdxW-1:0] start_pidx;
  logic [IdxW-1:0] cur_pidx;
  logic [IdxW-1:0] first_pidx;
  logic [IdxW-1:0] nxt_pidx;
  logic [CntW-1:0] nxt_idx;
  logic            sel_tick;
  logic            last_bit;

  // Length 0 or anything past DATA_BIT selects the full word.
  assign bit_len_ext = {1'b0, i_bit_len};
  assign eff_len     = ((bit_len_ext == Zero) || (bit_len_ext > DataBitLen)) ? DataBitLen
                                                                           : bit_len_ext;
  assign start_pidx  = pat_idx(eff_len, Zero, i_msb_first);

  assign cur_pidx   = pat_idx(len_q, idx_q, msb_q);
  assign first_pidx = pat_idx(len_q, Zero, msb_q);
  assign nxt_idx    = idx_q + One;
  assign nxt_pidx   = pat_idx(len_q, nxt_idx, msb_q);
  assign sel_tick   = mask_q[cur_pidx] ? i_tick_high : i_tick_low;
  assign last_bit   = (idx_q == (len_q - One));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    len_d       = len_q;
    msb_d       = msb_q;
    rep_d       = rep_q;
    pass_d      = pass_q;
    tick_d      = tick_q;
    idx_d       = idx_q;
    out_d       = out_q;
    bit_tick_d  = 1'b0;
    done_tick_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          data_d  = i_data;
          mask_d  = i_freq_mask;
          len_d   = eff_len;
          msb_d   = i_msb_first;
          rep_d   = i_repeat_num;
          pass_d  = '0;
          tick_d  = '0;
          idx_d   = '0;
          out_d   = i_data[start_pidx];
          state_d = StShift;
        end else begin
          unique case (i_idle_mode)
            ModeLow:    out_d = 1'b0;
            ModeHigh:   out_d = 1'b1;
            ModeKeep:   out_d = out_q;
            ModeRepeat: out_d = 1'b0;
          endcase
        end
      end

      StShift: begin
        if (i_stop) begin
          // Abort: o_data holds this cycle, the idle rule takes over next cycle.
          state_d = StIdle;
        end else if (sel_tick) begin
          if (tick_q == TickLast) begin
            tick_d     = '0;
            bit_tick_d = 1'b1;
            if (last_bit) begin
              if ((pass_q < rep_q) || (i_idle_mode == ModeRepeat)) begin
                // Next pass starts immediately from the latched word.
                pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
                idx_d  = '0;
                out_d  = data_q[first_pidx];
              end else begin
                state_d = StDone;
              end
            end else begin
              idx_d = nxt_idx;
              out_d = data_q[nxt_pidx];
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end

      StDone: begin
        // i_stop here also lands in IDLE; the done tick is issued regardless.
        done_tick_d = 1'b1;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      mask_q      <= '0;
      len_q       <= '0;
      msb_q       <= 1'b0;
      rep_q       <= '0;
      pass_q      <= '0;
      tick_q      <= '0;
      idx_q       <= '0;
      out_q       <= 1'b0;
      bit_tick_q  <= 1'b0;
      done_tick_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
      rep_q       <= rep_d;
      pass_q      <= pass_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      bit_tick_q  <= bit_tick_d;
      done_tick_q <= done_tick_d;
      busy_q      <= busy_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_bit_tick  = bit_tick_q;
  assign o_data      = out_q;
  assign o_done_tick = done_tick_q;

endmodule

// File: tb/tb_serial_out_ms.sv
// Bench for serial_out_ms: directed scenarios plus randomized transactions,
// every cycle compared against a transaction-level reference model.
module tb_serial_out_ms;

  localparam int unsigned DB  = 8;
  localparam int unsigned TPB = 4;
  localparam int unsigned LW  = 4;

  logic          clk;
  logic          rst_n;
  logic          i_tick_high;
  logic          i_tick_low;
  logic          i_start;
  logic          i_stop;
  logic [1:0]    i_idle_mode;
  logic          i_msb_first;
  logic [LW-1:0] i_bit_len;
  logic [7:0]    i_repeat_num;
  logic [DB-1:0] i_data;
  logic [DB-1:0] i_freq_mask;
  logic          o_busy;
  logic          o_bit_tick;
  logic          o_data;
  logic          o_done_tick;

  serial_out_ms #(
    .DATA_BIT    (DB),
    .TICK_PER_BIT(TPB),
    .LEN_W       (LW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick_high (i_tick_high),
    .i_tick_low  (i_tick_low),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_idle_mode (i_idle_mode),
    .i_msb_first (i_msb_first),
    .i_bit_len   (i_bit_len),
    .i_repeat_num(i_repeat_num),
    .i_data      (i_data),
    .i_freq_mask (i_freq_mask),
    .o_busy      (o_busy),
    .o_bit_tick  (o_bit_tick),
    .o_data      (o_data),
    .o_done_tick (o_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: one pass is the list of pattern bits in send order.
  int   m_phase;  // 0 idle, 1 shifting, 2 done
  logic m_bits[DB];
  logic m_msk[DB];
  int   m_len, m_pos, m_ticks, m_pass, m_rep;
  logic m_out, m_btick, m_dtick;

  int cyc;
  int hi_div, lo_div;
  int hook_sel;
  int cnt_bt, cnt_busy, cnt_done, seq_n, seq_len;
  logic [31:0] seq_word;
  int bt_at[32];

  function automatic int eff_len(input int bl);
    return (bl == 0 || bl > int'(DB)) ? int'(DB) : bl;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_pos = 0; m_ticks = 0; m_pass = 0; m_rep = 0;
    m_out = 1'b0; m_btick = 1'b0; m_dtick = 1'b0;
  endtask

  task automatic model_step();
    logic sel;
    logic [2:0] p3;
    m_btick = 1'b0;
    m_dtick = 1'b0;
    case (m_phase)
      0: begin
        if (i_start && !i_stop) begin
          m_len = eff_len(int'(i_bit_len));
          for (int k = 0; k < m_len; k++) begin
            p3 = i_msb_first ? 3'(m_len - 1 - k) : 3'(k);
            m_bits[k] = i_data[p3];
            m_msk[k]  = i_freq_mask[p3];
          end
          m_pos = 0; m_ticks = 0; m_pass = 0; m_rep = int'(i_repeat_num);
          m_out = m_bits[0];
          m_phase = 1;
        end else begin
          if (i_idle_mode == 2'b01) m_out = 1'b1;
          else if (i_idle_mode != 2'b10) m_out = 1'b0;
        end
      end
      1: begin
        if (i_stop) begin
          m_phase = 0;
        end else begin
          sel = m_msk[m_pos] ? i_tick_high : i_tick_low;
          if (sel) begin
            m_ticks++;
            if (m_ticks == int'(TPB)) begin
              m_ticks = 0;
              m_btick = 1'b1;
              m_pos++;
              if (m_pos == m_len) begin
                if (m_pass < m_rep || i_idle_mode == 2'b11) begin
                  if (m_pass < 255) m_pass++;
                  m_pos = 0;
                  m_out = m_bits[0];
                end else begin
                  m_phase = 2;
                end
              end else begin
                m_out = m_bits[m_pos];
              end
            end
          end
        end
      end
      default: begin
        m_dtick = 1'b1;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic set_ticks();
    i_tick_high = (hi_div == 0) ? 1'($urandom_range(0, 1)) : ((cyc % hi_div) == 0);
    i_tick_low  = (lo_div == 0) ? 1'($urandom_range(0, 1)) : ((cyc % lo_div) == 0);
  endtask

  // One clock: drive ticks, advance the model on the edge, compare 1 ns later.
  task automatic step();
    set_ticks();
    @(posedge clk);
    model_step();
    #1;
    check_val("o_data", o_data, m_out);
    check_val("o_busy", o_busy, (m_phase != 0));
    check_val("o_bit_tick", o_bit_tick, m_btick);
    check_val("o_done_tick", o_done_tick, m_dtick);
    cyc++;
  endtask

  task automatic capture();
    if (o_busy) cnt_busy++;
    if (o_bit_tick) begin
      if (cnt_bt < 32) bt_at[cnt_bt] = cyc;
      cnt_bt++;
    end
    if (o_done_tick) cnt_done++;
    if (seq_n == 0 || (o_bit_tick && seq_n < seq_len)) begin
      seq_word[seq_n] = o_data;
      seq_n++;
    end
  endtask

  task automatic hook(input int n);
    case (hook_sel)
      1: if (n == 10) i_data = ~i_data;
      2: begin
        i_start = (m_phase == 1);
        i_stop  = (m_phase == 1 && m_pos == 3 && m_ticks == 2);
      end
      3: begin
        i_stop  = ($urandom_range(0, 99) == 0);
        i_start = (m_phase == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if ($urandom_range(0, 15) == 0) i_data = DB'($urandom);
        if (n > 200 && i_idle_mode == 2'b11) i_idle_mode = 2'b00;
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] m, input int l, input logic msb,
                      input logic [7:0] rep, input logic [1:0] mode, input int budget);
    int n;
    i_data = d; i_freq_mask = m; i_bit_len = LW'(l); i_msb_first = msb;
    i_repeat_num = rep; i_idle_mode = mode; i_start = 1'b1; i_stop = 1'b0;
    cnt_bt = 0; cnt_busy = 0; cnt_done = 0; seq_n = 0; seq_word = '0;
    seq_len = eff_len(l);
    step();
    i_start = 1'b0;
    capture();
    n = 0;
    while (m_phase != 0 && n < budget) begin
      hook(n);
      step();
      capture();
      n++;
    end
    if (n >= budget) check_val("timeout_idle", o_busy, 0);
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_tick_high = 1'b0; i_tick_low = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_idle_mode = 2'b00; i_msb_first = 1'b0; i_bit_len = '0; i_repeat_num = '0;
    i_data = '0; i_freq_mask = '0;
    cyc = 0; hi_div = 1; lo_div = 0; hook_sel = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data", o_data, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_bit_tick", o_bit_tick, 0);
    check_val("rst_done_tick", o_done_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Full-rate LSB-first 0xA5
    hi_div = 1; lo_div = 0; hook_sel = 0;
    send(8'hA5, 8'hFF, 8, 1'b0, 8'd0, 2'b00, 200);
    check_val("a_seq", seq_word, 32'hA5);
    check_val("a_bit_ticks", cnt_bt, 8);
    check_val("a_busy_cycles", cnt_busy, 33);
    check_val("a_done_ticks", cnt_done, 1);
    repeat (2) step();
    check_val("a_idle_low", o_data, 0);

    // Mixed rates: low-rate bits take 12 cycles, high-rate bits 4
    hi_div = 1; lo_div = 3;
    send(8'h0F, 8'hF0, 8, 1'b0, 8'd0, 2'b00, 400);
    for (int k = 1; k < 8; k++)
      check_val($sformatf("mix_len_bit%0d", k), bt_at[k] - bt_at[k-1], (k <= 3) ? 12 : 4);
    repeat (2) step();

    // MSB-first, L=5
    hi_div = 1; lo_div = 0;
    send(8'h13, 8'hFF, 5, 1'b1, 8'd0, 2'b00, 200);
    check_val("msb_seq", seq_word, 32'h19);
    check_val("msb_done", cnt_done, 1);
    repeat (2) step();

    // Three passes, data changed mid-pass, idle HIGH
    hook_sel = 1;
    send(8'h5A, 8'hFF, 8, 1'b0, 8'd2, 2'b01, 400);
    check_val("rep_bit_ticks", cnt_bt, 24);
    check_val("rep_busy_cycles", cnt_busy, 97);
    check_val("rep_done_ticks", cnt_done, 1);
    repeat (2) step();
    check_val("rep_idle_high", o_data, 1);

    // Abort at tick 2 of bit 3, start held during SHIFT, idle KEEP
    hook_sel = 2;
    send(8'h08, 8'hFF, 8, 1'b0, 8'd0, 2'b10, 200);
    check_val("stop_bit_ticks", cnt_bt, 3);
    check_val("stop_done_ticks", cnt_done, 0);
    check_val("stop_hold", o_data, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("stop_keep", o_data, 1);
    end

    // Randomized transactions
    hook_sel = 3;
    for (int t = 0; t < 40; t++) begin
      hi_div = $urandom_range(0, 3);
      lo_div = $urandom_range(0, 3);
      send(8'($urandom), 8'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2000);
      i_idle_mode = 2'($urandom_range(0, 2));
      repeat ($urandom_range(1, 3)) step();
    end

    // Async reset mid-SHIFT, then start+stop together must stay idle
    hook_sel = 0; hi_div = 1; lo_div = 0;
    i_data = 8'hFF; i_freq_mask = 8'hFF; i_bit_len = LW'(8); i_msb_first = 1'b0;
    i_repeat_num = 8'd0; i_idle_mode = 2'b00; i_start = 1'b1; i_stop = 1'b0;
    step();
    i_start = 1'b0;
    repeat (9) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_data", o_data, 0);
    check_val("arst_busy", o_busy, 0);
    check_val("arst_bit_tick", o_bit_tick, 0);
    check_val("arst_done_tick", o_done_tick, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    i_start = 1'b1;
    i_stop  = 1'b1;
    step();
    check_val("start_stop_idle", o_busy, 0);
    i_start = 1'b0;
    i_stop  = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_out_ms.md
Name: serial_out_ms

Overview:
- Next-generation serial pattern generator; successor to the fixed-length single-rate serial output block.
- Shifts out a latched word of run-time length, LSB- or MSB-first.
- Each bit has its own rate, chosen from two external tick sources by a per-bit frequency mask.
- Adds a programmable repeat count and a busy flag. Sits between the register/config bank and the output pin driver.

Parameters:
- DATA_BIT, 32: maximum word length in bits (2..64).
- TICK_PER_BIT, 16: selected-tick pulses per bit (1..256).
- LEN_W, 6: width of i_bit_len; must satisfy 2^LEN_W >= DATA_BIT.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- i_tick_high  in  1: high-rate tick, 1-cycle pulse.
- i_tick_low  in  1: low-rate tick, 1-cycle pulse.
- i_start  in  1: start request, sampled in IDLE only.
- i_stop  in  1: abort, highest priority.
- i_idle_mode  in  2: 00 LOW, 01 HIGH, 10 KEEP, 11 REPEAT.
- i_msb_first  in  1: 1 = MSB of the active length goes first.
- i_bit_len  in  LEN_W: number of bits to send; 0 or >DATA_BIT means DATA_BIT.
- i_repeat_num  in  8: extra passes after the first (0 = single pass).
- i_data  in  DATA_BIT: pattern.
- i_freq_mask  in  DATA_BIT: bit k=1 means pattern bit k uses i_tick_high, 0 means i_tick_low.
- o_busy  out  1: high in SHIFT and DONE.
- o_bit_tick  out  1: 1-cycle pulse at the end of each bit.
- o_data  out  1: serial output, registered.
- o_done_tick  out  1: 1-cycle pulse after the final pass.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0. Counters, buffers and latched config cleared.
- All outputs are registered and change only on clk rising edges.
- IDLE:
  - o_data follows i_idle_mode, with one cycle of latency: LOW gives 0, HIGH gives 1, KEEP holds the current value, REPEAT gives 0.
  - When i_start=1 and i_stop=0, the block latches i_data, i_freq_mask, the effective length L, i_msb_first and i_repeat_num. It clears the tick counter, bit index and pass counter, then goes to SHIFT.
  - On that same edge o_data takes the first bit: bit 0 when LSB-first, bit L-1 when MSB-first.
  - If i_start and i_stop are both 1, the block stays in IDLE.
- SHIFT:
  - The bit index k runs 0..L-1. The pattern bit sent is data[k] (LSB-first) or data[L-1-k] (MSB-first). The mask bit follows the same pattern index.
  - The selected tick is i_tick_high if the mask bit is 1, otherwise i_tick_low. The unselected tick is ignored, including when both ticks pulse in the same cycle.
  - Each selected tick increments the 8-bit tick counter. On the selected tick with count = TICK_PER_BIT-1:
    - the counter clears;
    - o_bit_tick=1 on the next cycle;
    - o_data moves to the next bit.
  - So each bit lasts exactly TICK_PER_BIT selected ticks.
  - At the end of bit L-1:
    - If pass < repeat_num, or i_idle_mode==REPEAT (sampled live): pass increments, saturating at 255. The bit index resets to 0 and o_data takes the first bit again with no gap cycle. The latched data is reused; i_data is NOT resampled.
    - Otherwise go to DONE; o_data holds the last bit.
  - i_stop=1 has the highest priority: the next state is IDLE, there is no o_bit_tick and no o_done_tick, and o_data applies the idle rule from the following cycle.
  - i_start is ignored while in SHIFT.
- DONE (exactly 1 cycle):
  - o_done_tick=1 on the cycle after entry.
  - o_data holds the last bit, then the next state is IDLE.
  - i_stop in DONE also goes to IDLE; the done tick is still issued.
- Latency: i_start sampled at edge N gives the first bit on o_data after edge N. The first o_bit_tick comes TICK_PER_BIT selected ticks later.
- Widths:
  - the bit index has LEN_W+1 bits;
  - the effective-length compare uses unsigned arithmetic;
  - TICK_PER_BIT=1 ends each bit on every selected tick.

Test Plan:
- DATA_BIT=8, TICK_PER_BIT=4, L=8, LSB-first, data=0xA5, mask=0xFF, i_tick_high every cycle, repeat 0, idle LOW:
  - o_data = 1,0,1,0,0,1,0,1, each held 4 cycles;
  - 8 o_bit_tick pulses;
  - one o_done_tick;
  - o_data returns to 0;
  - o_busy high for 33 cycles.
- Mixed rates: data=0x0F, mask=0xF0, i_tick_high every cycle, i_tick_low every 3rd cycle:
  - bits 0-3 (value 1) last 12 cycles each;
  - bits 4-7 (value 0) last 4 cycles each.
- MSB-first, L=5, data=0x13: o_data = 1,0,0,1,1, then done.
- repeat_num=2, idle HIGH:
  - 3 back-to-back passes with no gap and 24 o_bit_ticks;
  - i_data changed during pass 1 has no effect;
  - a single o_done_tick;
  - o_data returns to 1.
- i_stop at tick 2 of bit 3, idle KEEP:
  - IDLE next cycle, no done tick;
  - o_data holds bit 3's value;
  - an i_start held during SHIFT is ignored.
- Async reset mid-SHIFT (rst_n low between edges): o_data, o_busy, o_bit_tick and o_done_tick all go to 0 immediately. After release, with i_start=1 and i_stop=1 together, the block stays in IDLE.
